countdown_timer: RTL and testbench

Four-digit MM:SS countdown timer, the down-counting counterpart of the stopwatch. Loads a BCD preset, decrements once per second while running, and flags expiry at 00:00. Drives the same four active-low seven-segment displays as the stopwatch. Sits beside the stopwatch on the board and shares its display encoding and 1 Hz prescaler scheme.

---
 rtl/stopwatch_pkg.sv | 31 +++
 rtl/seg7_encode.sv | 26 ++
 rtl/countdown_timer.sv | 135 +++++++++++++
 tb/tb_countdown_timer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch and countdown timer: segment codes,
// countdown FSM states, BCD digit limits and a digit-saturation helper.
package stopwatch_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSE   = 2'd2,
      EXPIRED = 2'd3
   } cd_state_t;

   localparam logic [3:0] ONES_MAX = 4'd9;
   localparam logic [3:0] TENS_MAX = 4'd5;

   function automatic logic [3:0] sat_digit(input logic [3:0] d, input logic [3:0] lim);
      return (d > lim) ? lim : d;
   endfunction

endpackage

// File: rtl/seg7_encode.sv
// BCD digit to active-low seven-segment code; codes 10-15 blank the display.
module seg7_encode
   import stopwatch_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Segment lookup
   always_comb begin
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS countdown timer with BCD preset, 1 Hz prescaler and expiry flags.
// Optional COUNTDOWN_BLINK_EN blinks the displays at 1 Hz while expired.
module countdown_timer
   import stopwatch_pkg::*;
#(
   parameter int TICKS_PER_SEC = 50_000_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic       run,
   input  logic [3:0] preset_s0,
   input  logic [3:0] preset_s1,
   input  logic [3:0] preset_m0,
   input  logic [3:0] preset_m1,
   output logic [6:0] y,
   output logic [6:0] y_1,
   output logic [6:0] y_2,
   output logic [6:0] y_3,
   output logic       done,
   output logic       expired
);

   localparam int CW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CW-1:0] TICK_LAST = CW'(TICKS_PER_SEC - 1);

   cd_state_t  state, next_state;
   logic [3:0] s0, s1, m0, m1;
   logic [3:0] n_s0, n_s1, n_m0, n_m1;
   logic [CW-1:0] tick_cnt;
   logic       tick, is_zero, is_one, blank;
   logic [6:0] seg_s0, seg_s1, seg_m0, seg_m1;

   assign tick    = (state == RUN) && (tick_cnt == TICK_LAST);
   assign is_zero = (s0 == 4'd0) && (s1 == 4'd0) && (m0 == 4'd0) && (m1 == 4'd0);
   assign is_one  = (s0 == 4'd1) && (s1 == 4'd0) && (m0 == 4'd0) && (m1 == 4'd0);
   assign expired = (state == EXPIRED);

   // Next-state logic; load overrides every state
   always_comb begin
      next_state = state;
      if (load) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:    if (run && !is_zero) next_state = RUN;     else next_state = IDLE;
            RUN:     if (!run)            next_state = PAUSE;
                     else if (tick && is_one) next_state = EXPIRED;
                     else                 next_state = RUN;
            PAUSE:   if (run)             next_state = RUN;     else next_state = PAUSE;
            EXPIRED: next_state = EXPIRED;
            default: next_state = IDLE;
         endcase
      end
   end

   // BCD borrow chain for one decrement
   always_comb begin
      n_s0 = s0;
      n_s1 = s1;
      n_m0 = m0;
      n_m1 = m1;
      if (s0 != 4'd0) begin
         n_s0 = s0 - 4'd1;
      end else begin
         n_s0 = ONES_MAX;
         if (s1 != 4'd0) begin
            n_s1 = s1 - 4'd1;
         end else begin
            n_s1 = TENS_MAX;
            if (m0 != 4'd0) begin
               n_m0 = m0 - 4'd1;
            end else begin
               n_m0 = ONES_MAX;
               if (m1 != 4'd0) n_m1 = m1 - 4'd1; else n_m1 = 4'd0;
            end
         end
      end
   end

   // State, prescaler, digit and done registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         s0       <= 4'd0;
         s1       <= 4'd0;
         m0       <= 4'd0;
         m1       <= 4'd0;
         tick_cnt <= '0;
         done     <= 1'b0;
      end else begin
         state <= next_state;
         done  <= 1'b0;
         if (load) begin
            s0       <= sat_digit(preset_s0, ONES_MAX);
            s1       <= sat_digit(preset_s1, TENS_MAX);
            m0       <= sat_digit(preset_m0, ONES_MAX);
            m1       <= sat_digit(preset_m1, TENS_MAX);
            tick_cnt <= '0;
         end else if (state == RUN && run) begin
            // run low in a tick cycle leaves tick_cnt parked on TICK_LAST
            tick_cnt <= tick ? '0 : tick_cnt + {{(CW-1){1'b0}}, 1'b1};
            if (tick) begin
               s0   <= n_s0;
               s1   <= n_s1;
               m0   <= n_m0;
               m1   <= n_m1;
               done <= is_one;
            end
`ifdef COUNTDOWN_BLINK_EN
         end else if (state == EXPIRED) begin
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + {{(CW-1){1'b0}}, 1'b1};
`endif
         end
      end
   end

`ifdef COUNTDOWN_BLINK_EN
   localparam logic [CW-1:0] TICK_HALF = CW'(TICKS_PER_SEC / 2);
   assign blank = (state == EXPIRED) && (tick_cnt >= TICK_HALF);
`else
   assign blank = 1'b0;
`endif

   seg7_encode u_seg_s0 (.bcd(s0), .seg(seg_s0));
   seg7_encode u_seg_s1 (.bcd(s1), .seg(seg_s1));
   seg7_encode u_seg_m0 (.bcd(m0), .seg(seg_m0));
   seg7_encode u_seg_m1 (.bcd(m1), .seg(seg_m1));

   assign y   = blank ? SEG_BLANK : seg_s0;
   assign y_1 = blank ? SEG_BLANK : seg_s1;
   assign y_2 = blank ? SEG_BLANK : seg_m0;
   assign y_3 = blank ? SEG_BLANK : seg_m1;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICKS_PER_SEC = 4.
module tb_countdown_timer;

   logic       clock = 1'b0;
   logic       reset, load, run;
   logic [3:0] preset_s0, preset_s1, preset_m0, preset_m1;
   logic [6:0] y, y_1, y_2, y_3;
   logic       done, expired;

   int vectors     = 0;
   int miscompares = 0;
   int done_seen   = 0;

   countdown_timer #(.TICKS_PER_SEC(4)) dut (
      .clock(clock), .reset(reset), .load(load), .run(run),
      .preset_s0(preset_s0), .preset_s1(preset_s1),
      .preset_m0(preset_m0), .preset_m1(preset_m1),
      .y(y), .y_1(y_1), .y_2(y_2), .y_3(y_3),
      .done(done), .expired(expired)
   );

   always #5 clock = ~clock;

   function automatic logic [6:0] seg_exp(input logic [3:0] d);
      case (d)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_disp(input string tag, input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] c, input logic [3:0] d);
      check_val(tag, {4'h0, y_3, y_2, y_1, y},
                {4'h0, seg_exp(a), seg_exp(b), seg_exp(c), seg_exp(d)});
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      if (done === 1'b1) done_seen++;
   endtask

   task automatic set_preset(input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] c, input logic [3:0] d);
      preset_m1 = a; preset_m0 = b; preset_s1 = c; preset_s0 = d;
   endtask

   initial begin
      reset = 1'b1; load = 1'b0; run = 1'b0;
      set_preset(4'd0, 4'd0, 4'd0, 4'd0);
      step(); step();
      check_val("rst_disp", {4'h0, y_3, y_2, y_1, y}, {4'h0, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000});
      check_val("rst_done", {31'd0, done}, 32'd0);
      check_val("rst_expired", {31'd0, expired}, 32'd0);
      reset = 1'b0;

      // 00:03 countdown to expiry
      load = 1'b1; set_preset(4'd0, 4'd0, 4'd0, 4'd3);
      step();
      load = 1'b0;
      check_disp("load_0003", 4'd0, 4'd0, 4'd0, 4'd3);
      done_seen = 0;
      run = 1'b1;
      for (int i = 1; i <= 13; i++) begin
         step();
         if (i == 4)  check_disp("pre_tick1", 4'd0, 4'd0, 4'd0, 4'd3);
         if (i == 5)  check_disp("tick1_0002", 4'd0, 4'd0, 4'd0, 4'd2);
         if (i == 9)  check_disp("tick2_0001", 4'd0, 4'd0, 4'd0, 4'd1);
         if (i == 12) check_val("no_done_early", {31'd0, done}, 32'd0);
         if (i == 13) begin
            check_disp("tick3_0000", 4'd0, 4'd0, 4'd0, 4'd0);
            check_val("done_pulse", {31'd0, done}, 32'd1);
            check_val("expired_rise", {31'd0, expired}, 32'd1);
         end
      end
      step();
      check_val("done_one_cycle", {31'd0, done}, 32'd0);
      for (int i = 0; i < 20; i++) step();
      check_disp("hold_0000", 4'd0, 4'd0, 4'd0, 4'd0);
      check_val("expired_hold", {31'd0, expired}, 32'd1);
      check_val("done_count", done_seen, 32'd1);

      // 10:00 borrows through every digit
      run = 1'b0; load = 1'b1; set_preset(4'd1, 4'd0, 4'd0, 4'd0);
      step();
      load = 1'b0;
      check_val("load_clears_exp", {31'd0, expired}, 32'd0);
      run = 1'b1;
      for (int i = 0; i < 5; i++) step();
      check_val("borrow_0959", {4'h0, y_3, y_2, y_1, y},
                {4'h0, 7'b1000000, 7'b0010000, 7'b0010010, 7'b0010000});
      run = 1'b0;

      // pause retains the prescaler
      load = 1'b1; set_preset(4'd0, 4'd0, 4'd0, 4'd5);
      step();
      load = 1'b0; run = 1'b1;
      step();
      for (int i = 0; i < 6; i++) step();
      check_disp("run6_0004", 4'd0, 4'd0, 4'd0, 4'd4);
      run = 1'b0;
      for (int i = 0; i < 10; i++) step();
      check_disp("pause_0004", 4'd0, 4'd0, 4'd0, 4'd4);
      run = 1'b1;
      step(); step();
      check_disp("resume_hold", 4'd0, 4'd0, 4'd0, 4'd4);
      step();
      check_disp("resume_0003", 4'd0, 4'd0, 4'd0, 4'd3);
      run = 1'b0;

      // load coinciding with a tick wins
      load = 1'b1; set_preset(4'd0, 4'd1, 4'd0, 4'd0);
      step();
      load = 1'b0; run = 1'b1;
      for (int i = 0; i < 4; i++) step();
      load = 1'b1; set_preset(4'd0, 4'd0, 4'd3, 4'd0);
      step();
      load = 1'b0;
      check_disp("load_wins", 4'd0, 4'd0, 4'd3, 4'd0);
      for (int i = 0; i < 4; i++) step();
      check_disp("idle_restart", 4'd0, 4'd0, 4'd3, 4'd0);
      step();
      check_disp("first_after_load", 4'd0, 4'd0, 4'd2, 4'd9);

      // saturation of out-of-range preset digits
      run = 1'b0; load = 1'b1; set_preset(4'd7, 4'hA, 4'd9, 4'hF);
      step();
      load = 1'b0;
      check_disp("sat_5959", 4'd5, 4'd9, 4'd5, 4'd9);

      // zero preset never starts
      done_seen = 0;
      load = 1'b1; run = 1'b1; set_preset(4'd0, 4'd0, 4'd0, 4'd0);
      step();
      load = 1'b0;
      for (int i = 0; i < 10; i++) step();
      check_disp("zero_stays", 4'd0, 4'd0, 4'd0, 4'd0);
      check_val("zero_no_done", done_seen, 32'd0);
      check_val("zero_no_exp", {31'd0, expired}, 32'd0);

      // reset mid-count overrides load
      load = 1'b1; set_preset(4'd0, 4'd0, 4'd0, 4'd9);
      step();
      load = 1'b0;
      for (int i = 0; i < 6; i++) step();
      check_disp("midcount_0008", 4'd0, 4'd0, 4'd0, 4'd8);
      reset = 1'b1; load = 1'b1;
      step();
      reset = 1'b0; load = 1'b0; run = 1'b0;
      check_disp("reset_mid", 4'd0, 4'd0, 4'd0, 4'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
